// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable terminal count MAX.
// Supports clamped parallel load, wrap or one-shot halt, and a combinational terminal-count flag.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   en       : count enable
//   up       : 1 = increment, 0 = decrement
//   load     : parallel load strobe; din is clamped to MAX
//   din      : load value
//   one_shot : 1 = halt at terminal, 0 = wrap
//   q        : registered count, 0..MAX
//   tc       : terminal count, combinational
//   done     : registered one-shot completion flag
module mod_updown_counter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_done;

  logic             w_term;
  logic [WIDTH-1:0] w_load_val;

  // Terminal depends on direction: top when rising, zero when falling.
  assign w_term     = up ? (r_q == MAX) : (r_q == '0);
  assign w_load_val = (din > MAX) ? MAX : din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_state <= S_RUN;
      r_q     <= w_load_val;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (en) begin
            if (!w_term) begin
              r_q <= up ? r_q + ONE : r_q - ONE;
            end else if (one_shot) begin
              r_state <= S_HALT;
              r_done  <= 1'b1;
            end else begin
              // Explicit wrap keeps the sequence modulo MAX+1
              // even when MAX is below the natural overflow.
              r_q <= up ? '0 : MAX;
            end
          end
        end
        S_HALT: begin
          r_q <= r_q;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign done = r_done;
  assign tc   = en & ~r_done & ~load & w_term;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: MAX=9 and default instances share stimulus.
// A reference model queues expected results; each test pops and compares.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic       one_shot;

  logic [3:0] q9;
  logic       tc9;
  logic       done9;
  logic [3:0] q15;
  logic       tc15;
  logic       done15;

  mod_updown_counter #(.WIDTH(4), .MAX(4'd9)) dut9 (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .din(din), .one_shot(one_shot),
    .q(q9), .tc(tc9), .done(done9)
  );

  mod_updown_counter dut15 (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .din(din), .one_shot(one_shot),
    .q(q15), .tc(tc15), .done(done15)
  );

  typedef struct packed {
    logic [3:0] q9;
    logic       d9;
    logic       tc9;
    logic [3:0] q15;
    logic       d15;
    logic       tc15;
  } exp_t;

  exp_t       sb[$];
  exp_t       x;
  exp_t       got;
  int         total;
  int         bad;
  logic [3:0] m9_q;
  logic       m9_d;
  logic [3:0] m15_q;
  logic       m15_d;
  logic       s_tc9;
  logic       s_tc15;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic mtc(input logic [3:0] q, input logic dn,
                               input logic [3:0] mx);
    return en && !dn && !load && (up ? (q == mx) : (q == 4'd0));
  endfunction

  function automatic void mstep(inout logic [3:0] q, inout logic dn,
                                input logic [3:0] mx);
    if (rst) begin
      q  = 4'd0;
      dn = 1'b0;
    end else if (load) begin
      q  = (din > mx) ? mx : din;
      dn = 1'b0;
    end else if (!dn && en) begin
      if (up && q == mx) begin
        if (one_shot) dn = 1'b1;
        else q = 4'd0;
      end else if (!up && q == 4'd0) begin
        if (one_shot) dn = 1'b1;
        else q = mx;
      end else begin
        q = up ? q + 4'd1 : q - 4'd1;
      end
    end
  endfunction

  function automatic exp_t obs();
    return {q9, done9, s_tc9, q15, done15, s_tc15};
  endfunction

  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic u, input logic os, input logic [3:0] d);
    exp_t y;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; one_shot = os; din = d;
    #1;
    s_tc9  = tc9;
    s_tc15 = tc15;
    y.tc9  = mtc(m9_q, m9_d, 4'd9);
    y.tc15 = mtc(m15_q, m15_d, 4'd15);
    mstep(m9_q, m9_d, 4'd9);
    mstep(m15_q, m15_d, 4'd15);
    y.q9  = m9_q;
    y.d9  = m9_d;
    y.q15 = m15_q;
    y.d15 = m15_d;
    sb.push_back(y);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 0, 4'd5);
    x = sb.pop_front(); got = obs(); total++;
    if (got !== x) begin
      bad++;
      $display("FAIL reset: got %h want %h", got, x);
    end
    total++;
    if ({q9, done9, q15, done15} !== 10'd0) begin
      bad++;
      $display("FAIL reset_zero: got %h want 0", {q9, done9, q15, done15});
    end
    cyc(0, 0, 0, 1, 0, 4'd0);
    x = sb.pop_front(); got = obs(); total++;
    if (got !== x) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", got, x);
    end
  endtask

  task automatic test_count_up();
    cyc(1, 0, 0, 1, 0, 4'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, 1, 1, 0, 4'd0);
      x = sb.pop_front(); got = obs(); total++;
      if (got !== x) begin
        bad++;
        $display("FAIL count_up[%0d]: got %h want %h", i, got, x);
      end
    end
    total++;
    if (q9 !== 4'd1) begin
      bad++;
      $display("FAIL count_up_wrap: got %0d want 1", q9);
    end
  endtask

  task automatic test_count_down();
    cyc(1, 0, 1, 0, 0, 4'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 11; i++) begin
      cyc(0, 0, 1, 0, 0, 4'd0);
      x = sb.pop_front(); got = obs(); total++;
      if (got !== x) begin
        bad++;
        $display("FAIL count_down[%0d]: got %h want %h", i, got, x);
      end
      if (i == 0) begin
        total++;
        if (s_tc9 !== 1'b1) begin
          bad++;
          $display("FAIL down_tc_at_zero: got %b want 1", s_tc9);
        end
      end
    end
    total++;
    if (q9 !== 4'd9) begin
      bad++;
      $display("FAIL count_down_wrap: got %0d want 9", q9);
    end
  endtask

  task automatic test_one_shot();
    cyc(0, 1, 0, 1, 1, 4'd7);
    x = sb.pop_front(); got = obs(); total++;
    if (got !== x) begin
      bad++;
      $display("FAIL os_load: got %h want %h", got, x);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, 1, 4'd0);
      x = sb.pop_front(); got = obs(); total++;
      if (got !== x) begin
        bad++;
        $display("FAIL os_run[%0d]: got %h want %h", i, got, x);
      end
    end
    total++;
    if ({q9, done9, s_tc9} !== {4'd9, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL os_halt: got %h want 9/1/0", {q9, done9, s_tc9});
    end
    cyc(0, 0, 1, 0, 0, 4'd0);
    x = sb.pop_front(); got = obs(); total++;
    if (got !== x) begin
      bad++;
      $display("FAIL os_halt_mode_flip: got %h want %h", got, x);
    end
    cyc(0, 1, 1, 1, 1, 4'd2);
    x = sb.pop_front(); got = obs(); total++;
    if ({q9, done9} !== {4'd2, 1'b0} || got !== x) begin
      bad++;
      $display("FAIL os_reload: got %h want %h", got, x);
    end
  endtask

  task automatic test_load();
    cyc(0, 1, 0, 1, 0, 4'd14);
    x = sb.pop_front(); got = obs(); total++;
    if ({q9, q15} !== {4'd9, 4'd14} || got !== x) begin
      bad++;
      $display("FAIL load_clamp: got %h want %h", got, x);
    end
    cyc(0, 1, 1, 1, 0, 4'd3);
    x = sb.pop_front(); got = obs(); total++;
    if (q9 !== 4'd3 || got !== x) begin
      bad++;
      $display("FAIL load_over_en: got %h want %h", got, x);
    end
    cyc(1, 1, 1, 1, 0, 4'd6);
    x = sb.pop_front(); got = obs(); total++;
    if (q9 !== 4'd0 || got !== x) begin
      bad++;
      $display("FAIL rst_over_load: got %h want %h", got, x);
    end
  endtask

  task automatic test_default_wrap();
    cyc(1, 0, 0, 1, 0, 4'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 21; i++) begin
      cyc(0, 0, 1, 1, 0, 4'd0);
      x = sb.pop_front(); got = obs(); total++;
      if (got !== x) begin
        bad++;
        $display("FAIL def_up[%0d]: got %h want %h", i, got, x);
      end
    end
    total++;
    if (q15 !== 4'd5) begin
      bad++;
      $display("FAIL def_wrap: got %0d want 5", q15);
    end
    cyc(0, 0, 1, 0, 0, 4'd0);
    x = sb.pop_front(); got = obs(); total++;
    if (q15 !== 4'd4 || got !== x) begin
      bad++;
      $display("FAIL def_flip_dir: got %h want %h", got, x);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 1, 0, 4'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 1, 0, 4'd0);
      void'(sb.pop_front());
    end
    cyc(1, 0, 1, 1, 0, 4'd0);
    x = sb.pop_front(); got = obs(); total++;
    if (q9 !== 4'd0 || got !== x) begin
      bad++;
      $display("FAIL rst_mid: got %h want %h", got, x);
    end
    cyc(0, 0, 1, 1, 0, 4'd0);
    x = sb.pop_front(); got = obs(); total++;
    if (q9 !== 4'd1 || got !== x) begin
      bad++;
      $display("FAIL rst_resume: got %h want %h", got, x);
    end
    cyc(0, 1, 0, 1, 1, 4'd8);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1, 4'd0);
      void'(sb.pop_front());
    end
    cyc(1, 0, 1, 1, 1, 4'd0);
    x = sb.pop_front(); got = obs(); total++;
    if ({q9, done9} !== 5'd0 || got !== x) begin
      bad++;
      $display("FAIL rst_halt: got %h want %h", got, x);
    end
  endtask

  task automatic test_back_to_back();
    logic r;
    logic l;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 4);
      l = ($urandom_range(0, 99) < 10);
      cyc(r, l, 1'($urandom_range(0, 9) != 0), 1'($urandom),
          1'($urandom), 4'($urandom));
      x = sb.pop_front(); got = obs(); total++;
      if (got !== x) begin
        bad++;
        $display("FAIL b2b[%0d]: got %h want %h", i, got, x);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1;
    one_shot = 1'b0; din = 4'd0;
    m9_q = 4'd0; m9_d = 1'b0; m15_q = 4'd0; m15_d = 1'b0;
    s_tc9 = 1'b0; s_tc15 = 1'b0;
    test_reset();
    test_count_up();
    test_count_down();
    test_one_shot();
    test_load();
    test_default_wrap();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1, setting the terminal (highest) count value (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port din, input, WIDTH bits: parallel load value.
REQ-009 The block SHALL have port one_shot, input, 1 bit: mode, 1 = halt at terminal, 0 = free-running wrap.
REQ-010 The block SHALL have port q, output, WIDTH bits: current count, registered.
REQ-011 The block SHALL have port tc, output, 1 bit: terminal-count indication, combinational.
REQ-012 The block SHALL have port done, output, 1 bit: one-shot completion flag, registered.

Function
REQ-013 Per-edge priority SHALL be: rst > load > en; with none of them asserted, q and done hold.
REQ-014 Count range SHALL be 0..MAX inclusive; q SHALL never hold a value above MAX.
REQ-015 On load, q SHALL take din if din <= MAX, else MAX (clamp); done SHALL clear to 0 the same edge.
REQ-016 Load SHALL take effect regardless of en, up, one_shot or done.
REQ-017 The terminal condition SHALL be (up=1 and q=MAX) or (up=0 and q=0).
REQ-018 tc SHALL equal en AND not done AND not load AND terminal condition, evaluated combinationally in the current cycle.
REQ-019 The internal state machine SHALL have two states: RUN (done=0) and HALT (done=1).
REQ-020 RUN with en=1, not terminal: q SHALL become q+1 (up=1) or q-1 (up=0) on the next edge.
REQ-021 RUN with en=1, terminal, one_shot=0: q SHALL wrap to 0 (up) or MAX (down) on the next edge; state stays RUN.
REQ-022 RUN with en=1, terminal, one_shot=1: q SHALL hold its terminal value and state SHALL go to HALT (done=1) on the next edge.
REQ-023 HALT: q SHALL hold regardless of en, up or one_shot; exit only via load (to RUN) or rst.
REQ-024 Changing up while en=1 SHALL take effect on the very next edge with no lost or extra count.
REQ-025 Changing one_shot in HALT SHALL NOT leave HALT.
REQ-026 Arithmetic SHALL be modulo MAX+1 and SHALL not depend on WIDTH-bit natural overflow when MAX < 2**WIDTH-1.
REQ-027 Latency: q SHALL reflect any load/count/reset exactly one clk edge after the controlling inputs are sampled.

Reset
REQ-028 With rst=1 at a rising edge, q SHALL become 0, done 0, state RUN, overriding load and en.
REQ-029 Reset asserted mid-count or in HALT SHALL behave identically to REQ-028; no asynchronous effect between edges.
REQ-030 After the rst edge, tc SHALL be 0 unless en=1, up=0 (q=0 is terminal when counting down).

Verification
REQ-031 WIDTH=4, MAX=9, one_shot=0, up=1, en=1 from reset: q sequence 0,1,...,9,0,1; tc=1 only while q=9.
REQ-032 Same parameters, up=0 from reset: q sequence 0,9,8,...,0,9; tc=1 while q=0.
REQ-033 one_shot=1, up=1, load din=7, then en=1: q 7,8,9,9,9...; done=1 from the edge after q reaches 9; tc=0 once done=1; load din=2 -> q=2, done=0.
REQ-034 load with din=14 (MAX=9) -> q=9; load and en asserted together -> load value wins; rst and load together -> q=0.
REQ-035 Default parameters (WIDTH=4, MAX=15), free-running up: 0..15 then wraps to 0; flip up at q=5 -> next q=4.
REQ-036 rst pulsed at q=6 mid-count and again in HALT -> q=0, done=0 on that edge; counting resumes next edge if en=1.
